// File: rtl/motor_sup_pkg.sv
// Shared encodings, default parameter values and the command saturation helper
// used by the motor supervisor.
package motor_sup_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_SEEK    = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_WDOG    = 2'd1,
    FC_HOME_TO = 2'd2
  } fault_code_e;

  localparam logic [9:0]  VMAX_DEF       = 10'd400;
  localparam logic [9:0]  HOME_VOLT_DEF  = 10'd150;
  localparam int unsigned WDOG_US_DEF    = 20000;
  localparam int unsigned HOME_TO_US_DEF = 5000000;
  localparam int unsigned DEB_CYC_DEF    = 16;

  // Clamp a signed 10-bit command to +/-vmax; widened by one bit so -512 cannot wrap.
  function automatic logic [9:0] sat_cmd(input logic [9:0] cmd, input logic [9:0] vmax);
    logic signed [10:0] c;
    logic signed [10:0] v;
    logic [10:0]        nv;
    c  = {cmd[9], cmd};
    v  = {1'b0, vmax};
    nv = 11'd0 - {1'b0, vmax};
    if (c > v) begin
      sat_cmd = vmax;
    end else if (c < -v) begin
      sat_cmd = nv[9:0];
    end else begin
      sat_cmd = cmd;
    end
  endfunction

endpackage

// File: rtl/motor_supervisor_beam_debounce.sv
// Beam sensor conditioning: 2-FF synchronizer followed by a DEB_CYC-cycle
// level debouncer with registered rise/fall pulses aligned to beam_db_o.
module beam_debounce
  import motor_sup_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic beam_i,
  output logic beam_db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(DEB_CYC + 1);

  logic [1:0]    sync_q;
  logic          db_q, db_d;
  logic          rise_q, fall_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CW'(DEB_CYC - 1)) begin
        db_d  = sync_q[1];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
      db_q   <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], beam_i};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      rise_q <= ~db_q & db_d;
      fall_q <= db_q & ~db_d;
    end
  end

  assign beam_db_o = db_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;

endmodule

// File: rtl/motor_supervisor.sv
// Motor supervisor: RUN passthrough with saturation and command watchdog,
// beam-referenced homing (SEEK/BACKOFF) with timeout, and a latched FAULT state.
module motor_supervisor
  import motor_sup_pkg::*;
#(
  parameter logic [9:0]  VMAX       = VMAX_DEF,
  parameter logic [9:0]  HOME_VOLT  = HOME_VOLT_DEF,
  parameter int unsigned WDOG_US    = WDOG_US_DEF,
  parameter int unsigned HOME_TO_US = HOME_TO_US_DEF,
  parameter int unsigned DEB_CYC    = DEB_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_us,
  input  logic [9:0]  sw_cmd,
  input  logic        sw_cmd_wr,
  input  logic        run_en,
  input  logic        home_req,
  input  logic        fault_clr,
  input  logic        beam,
  input  logic [31:0] enc_count,
  output logic [9:0]  volt_out,
  output logic [2:0]  state,
  output logic        homed,
  output logic        fault,
  output logic [31:0] home_pos,
  output logic [1:0]  fault_code
);

  localparam logic [31:0] WDOG_LIM  = WDOG_US;
  localparam logic [31:0] HOME_LIM  = HOME_TO_US;
  localparam logic [9:0]  NEG_HOME  = 10'd0 - HOME_VOLT;

  state_e      state_q, state_d;
  fault_code_e code_q, code_d;
  logic [9:0]  volt_q, volt_d;
  logic        homed_q, homed_d;
  logic        fault_q, fault_d;
  logic [31:0] home_pos_q, home_pos_d;
  logic [31:0] wdog_q, wdog_d;
  logic [31:0] home_t_q, home_t_d;
  logic        beam_db_s, beam_rise_s, beam_fall_s;
  logic        wdog_hit_s, home_hit_s, homing_s;

  beam_debounce #(.DEB_CYC(DEB_CYC)) u_beam_debounce (
    .clk       (clk),
    .reset     (reset),
    .beam_i    (beam),
    .beam_db_o (beam_db_s),
    .rise_o    (beam_rise_s),
    .fall_o    (beam_fall_s)
  );

  always_comb begin
    homing_s   = (state_q == ST_SEEK) || (state_q == ST_BACKOFF);
    wdog_hit_s = (state_q == ST_RUN) && (wdog_q >= WDOG_LIM);
    home_hit_s = homing_s && (home_t_q >= HOME_LIM);

    // Both timers saturate at their limit and are held at zero outside their states.
    wdog_d = '0;
    if ((state_q == ST_RUN) && !sw_cmd_wr) begin
      if (ce_us && (wdog_q < WDOG_LIM)) wdog_d = wdog_q + 32'd1;
      else                              wdog_d = wdog_q;
    end else begin
      wdog_d = '0;
    end
    home_t_d = '0;
    if (homing_s) begin
      if (ce_us && (home_t_q < HOME_LIM)) home_t_d = home_t_q + 32'd1;
      else                                home_t_d = home_t_q;
    end else begin
      home_t_d = '0;
    end

    state_d    = state_q;
    code_d     = code_q;
    homed_d    = homed_q;
    home_pos_d = home_pos_q;
    case (state_q)
      ST_IDLE: begin
        if (home_req)    state_d = ST_SEEK;
        else if (run_en) state_d = ST_RUN;
        else             state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (wdog_hit_s) begin
          state_d = ST_FAULT;
          code_d  = FC_WDOG;
        end else if (home_req) begin
          state_d = ST_SEEK;
        end else if (!run_en) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SEEK: begin
        if (home_hit_s) begin
          state_d = ST_FAULT;
          code_d  = FC_HOME_TO;
          homed_d = 1'b0;
        end else if (beam_rise_s) begin
          state_d    = ST_BACKOFF;
          home_pos_d = enc_count;
        end else begin
          state_d = ST_SEEK;
        end
      end
      ST_BACKOFF: begin
        if (home_hit_s) begin
          state_d = ST_FAULT;
          code_d  = FC_HOME_TO;
          homed_d = 1'b0;
        end else if (beam_fall_s && !beam_db_s) begin
          state_d = ST_IDLE;
          homed_d = 1'b1;
        end else begin
          state_d = ST_BACKOFF;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_IDLE;
          code_d  = FC_NONE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = FC_NONE;
      end
    endcase

    if ((state_d == ST_SEEK) && (state_q != ST_SEEK)) homed_d = 1'b0;

    // Drive level is chosen from the state being entered so it tracks transitions with no lag.
    case (state_d)
      ST_RUN: begin
        if (sw_cmd_wr)              volt_d = sat_cmd(sw_cmd, VMAX);
        else if (state_q == ST_RUN) volt_d = volt_q;
        else                        volt_d = 10'd0;
      end
      ST_SEEK:    volt_d = NEG_HOME;
      ST_BACKOFF: volt_d = HOME_VOLT;
      default:    volt_d = 10'd0;
    endcase
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      code_q     <= FC_NONE;
      volt_q     <= 10'd0;
      homed_q    <= 1'b0;
      fault_q    <= 1'b0;
      home_pos_q <= 32'd0;
      wdog_q     <= 32'd0;
      home_t_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      volt_q     <= volt_d;
      homed_q    <= homed_d;
      fault_q    <= fault_d;
      home_pos_q <= home_pos_d;
      wdog_q     <= wdog_d;
      home_t_q   <= home_t_d;
    end
  end

  assign volt_out   = volt_q;
  assign state      = state_q;
  assign homed      = homed_q;
  assign fault      = fault_q;
  assign home_pos   = home_pos_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_motor_supervisor.sv
// Self-checking bench for motor_supervisor: saturation table, hand-written homing,
// debounce, timeout, watchdog and reset sequences, then randomized traffic vs. a model.
module tb_motor_supervisor;

  localparam int VMAX = 400;
  localparam int HV   = 150;
  localparam int WD   = 20000;
  localparam int HT   = 100;

  logic        clk = 1'b0;
  logic        reset, ce_us, sw_cmd_wr, run_en, home_req, fault_clr, beam;
  logic [9:0]  sw_cmd;
  logic [31:0] enc_count;
  logic [9:0]  volt_out;
  logic [2:0]  state;
  logic        homed, fault;
  logic [31:0] home_pos;
  logic [1:0]  fault_code;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [9:0] cmd;
    int         exp;
  } vec_t;
  vec_t tbl[10];

  // behavioural reference state
  int m_st, m_volt, m_homed, m_code, m_wd, m_ht;

  motor_supervisor #(.HOME_TO_US(HT)) dut (
    .clk(clk), .reset(reset), .ce_us(ce_us), .sw_cmd(sw_cmd), .sw_cmd_wr(sw_cmd_wr),
    .run_en(run_en), .home_req(home_req), .fault_clr(fault_clr), .beam(beam),
    .enc_count(enc_count), .volt_out(volt_out), .state(state), .homed(homed),
    .fault(fault), .home_pos(home_pos), .fault_code(fault_code)
  );

  always #10 clk = ~clk;

  function automatic int volt_i();
    return int'($signed(volt_out));
  endfunction

  function automatic int clamp(int c, int lim);
    if (c > lim)  return lim;
    if (c < -lim) return -lim;
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_in();
    ce_us = 1'b0; sw_cmd_wr = 1'b0; run_en = 1'b0; home_req = 1'b0;
    fault_clr = 1'b0; beam = 1'b0; sw_cmd = 10'd0; enc_count = 32'd0;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_home();
    home_req = 1'b1; cyc(1); home_req = 1'b0;
  endtask

  // One model step from the rules, using the inputs presented at this edge.
  task automatic model_step();
    int  ns, cmd, nwd, nht;
    bit  wd_hit, ht_hit, homing;
    cmd    = int'($signed(sw_cmd));
    homing = (m_st == 2) || (m_st == 3);
    wd_hit = (m_st == 1) && (m_wd >= WD);
    ht_hit = homing && (m_ht >= HT);
    nwd    = ((m_st == 1) && !sw_cmd_wr) ? clamp(m_wd + int'(ce_us), WD) : 0;
    nht    = homing ? clamp(m_ht + int'(ce_us), HT) : 0;
    ns     = m_st;
    if (m_st == 0) begin
      ns = home_req ? 2 : (run_en ? 1 : 0);
    end else if (m_st == 1) begin
      if (wd_hit) begin ns = 4; m_code = 1; end
      else if (home_req) ns = 2;
      else if (!run_en) ns = 0;
    end else if (homing) begin
      if (ht_hit) begin ns = 4; m_code = 2; m_homed = 0; end
    end else if (m_st == 4) begin
      if (fault_clr) begin ns = 0; m_code = 0; end
    end
    if (ns == 2 && m_st != 2) m_homed = 0;
    if (ns == 1)      m_volt = sw_cmd_wr ? clamp(cmd, VMAX) : ((m_st == 1) ? m_volt : 0);
    else if (ns == 2) m_volt = -HV;
    else if (ns == 3) m_volt = HV;
    else              m_volt = 0;
    m_st = ns; m_wd = nwd; m_ht = nht;
  endtask

  initial begin
    bit seen_bo;
    int bo_volt, k;

    tbl[0] = '{10'h200, -400};
    tbl[1] = '{10'd100,  100};
    tbl[2] = '{10'd400,  400};
    tbl[3] = '{10'd401,  400};
    tbl[4] = '{10'd511,  400};
    tbl[5] = '{10'h370, -144};
    tbl[6] = '{10'd624, -400};
    tbl[7] = '{10'd623, -400};
    tbl[8] = '{10'h3FF,   -1};
    tbl[9] = '{10'd0,      0};

    // Reset state, sampled while reset is held
    clr_in();
    reset = 1'b1;
    cyc(2);
    chk("rst_state", int'(state), 0);
    chk("rst_volt", volt_i(), 0);
    chk("rst_homed", int'(homed), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_code", int'(fault_code), 0);
    chk("rst_home_pos", int'(home_pos), 0);
    reset = 1'b0;
    cyc(1);

    // Saturation table in RUN
    run_en = 1'b1;
    cyc(1);
    chk("run_entry_state", int'(state), 1);
    chk("run_entry_volt", volt_i(), 0);
    for (int i = 0; i < 10; i++) begin
      sw_cmd = tbl[i].cmd; sw_cmd_wr = 1'b1;
      cyc(1);
      sw_cmd_wr = 1'b0;
      chk($sformatf("sat_vec%0d", i), volt_i(), tbl[i].exp);
    end
    sw_cmd = 10'd77;
    cyc(2);
    chk("hold_without_wr", volt_i(), 0);
    run_en = 1'b0;
    cyc(1);
    chk("run_exit_state", int'(state), 0);
    chk("run_exit_volt", volt_i(), 0);

    // Homing with a rejected 10-cycle glitch and an accepted 20-cycle pulse
    do_reset();
    enc_count = 32'd999;
    pulse_home();
    chk("seek_state", int'(state), 2);
    chk("seek_volt", volt_i(), -HV);
    beam = 1'b1; cyc(10); beam = 1'b0;
    cyc(30);
    chk("glitch_no_move", int'(state), 2);
    enc_count = 32'd1234;
    beam = 1'b1;
    seen_bo = 1'b0; bo_volt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (!seen_bo && state == 3'd3) begin seen_bo = 1'b1; bo_volt = volt_i(); end
    end
    beam = 1'b0;
    enc_count = 32'd5555;
    chk("pulse_reached_backoff", int'(seen_bo), 1);
    chk("backoff_volt", bo_volt, HV);
    k = 0;
    while (k < 60 && state != 3'd0) begin cyc(1); k++; end
    chk("homing_done_state", int'(state), 0);
    chk("homed_set", int'(homed), 1);
    chk("home_pos", int'(home_pos), 1234);
    chk("idle_volt", volt_i(), 0);

    // Reset in the middle of BACKOFF
    pulse_home();
    chk("rehome_clears_homed", int'(homed), 0);
    beam = 1'b1;
    k = 0;
    while (k < 40 && state != 3'd3) begin cyc(1); k++; end
    chk("backoff_before_reset", int'(state), 3);
    #5;
    reset = 1'b1;
    #1;
    chk("async_rst_volt", volt_i(), 0);
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_homed", int'(homed), 0);
    chk("async_rst_home_pos", int'(home_pos), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    beam = 1'b0;

    // Homing timeout with the beam never seen
    do_reset();
    pulse_home();
    ce_us = 1'b1;
    k = 0;
    while (k < 300 && state != 3'd4) begin cyc(1); k++; end
    chk("timeout_state", int'(state), 4);
    chk("timeout_latency_ok", int'(k >= 99 && k <= 102), 1);
    chk("timeout_code", int'(fault_code), 2);
    chk("timeout_homed", int'(homed), 0);
    chk("timeout_volt", volt_i(), 0);
    chk("timeout_fault", int'(fault), 1);
    pulse_home();
    run_en = 1'b1; sw_cmd = 10'd50; sw_cmd_wr = 1'b1; cyc(1); sw_cmd_wr = 1'b0;
    cyc(2);
    chk("fault_ignores_strobes", int'(state), 4);
    chk("fault_volt_held_zero", volt_i(), 0);
    run_en = 1'b0;
    fault_clr = 1'b1; cyc(1); fault_clr = 1'b0;
    chk("fault_clr_state", int'(state), 0);
    chk("fault_clr_code", int'(fault_code), 0);
    ce_us = 1'b0;

    // Command watchdog
    do_reset();
    run_en = 1'b1;
    cyc(1);
    sw_cmd = 10'd100; sw_cmd_wr = 1'b1; cyc(1); sw_cmd_wr = 1'b0;
    chk("wd_cmd_volt", volt_i(), 100);
    ce_us = 1'b1;
    cyc(19990);
    chk("wd_not_early", int'(state), 1);
    k = 0;
    while (k < 30 && state != 3'd4) begin cyc(1); k++; end
    chk("wd_fault_state", int'(state), 4);
    chk("wd_fault_code", int'(fault_code), 1);
    chk("wd_fault_volt", volt_i(), 0);
    run_en = 1'b0; ce_us = 1'b0;
    fault_clr = 1'b1; cyc(1); fault_clr = 1'b0;
    chk("wd_clr_state", int'(state), 0);
    chk("wd_clr_fault", int'(fault), 0);

    // Randomized traffic (beam held clear) against the reference model
    do_reset();
    m_st = 0; m_volt = 0; m_homed = 0; m_code = 0; m_wd = 0; m_ht = 0;
    for (int i = 0; i < 3000; i++) begin
      ce_us     = 1'($urandom_range(0, 1));
      sw_cmd    = 10'($urandom);
      sw_cmd_wr = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 5) run_en = ~run_en;
      home_req  = ($urandom_range(0, 99) < 3);
      fault_clr = ($urandom_range(0, 99) < 4);
      enc_count = $urandom;
      @(posedge clk);
      model_step();
      #1;
      chk("rnd_state", int'(state), m_st);
      chk("rnd_volt", volt_i(), m_volt);
      chk("rnd_homed", int'(homed), m_homed);
      chk("rnd_fault", int'(fault), int'(m_st == 4));
      chk("rnd_code", int'(fault_code), m_code);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
